// File: rtl/flexbex_efpga_arbiter_if.sv
// flexbex_efpga_arbiter_if: bundles the per-core eFPGA request ports, the shared
// fabric port and the arbiter status. The arbiter takes the slave view, the
// cores/fabric side (or a bench) the master view.
interface flexbex_efpga_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    // Core side
    logic [N_REQ-1:0]    req_en_i;
    logic [2*N_REQ-1:0]  req_operator_i;
    logic [32*N_REQ-1:0] req_operand_a_i;
    logic [32*N_REQ-1:0] req_operand_b_i;
    logic [4*N_REQ-1:0]  req_delay_i;
    logic [N_REQ-1:0]    req_done_o;
    logic [N_REQ-1:0]    req_err_o;
    logic [31:0]         result_a_o;
    logic [31:0]         result_b_o;
    logic [31:0]         result_c_o;

    // Fabric side
    logic                fab_en_o;
    logic [1:0]          fab_operator_o;
    logic [31:0]         fab_operand_a_o;
    logic [31:0]         fab_operand_b_o;
    logic                fab_write_strobe_o;
    logic                fab_done_i;
    logic [31:0]         fab_result_a_i;
    logic [31:0]         fab_result_b_i;
    logic [31:0]         fab_result_c_i;

    // Status
    logic                busy_o;

    modport slave (
        input  req_en_i, req_operator_i, req_operand_a_i, req_operand_b_i, req_delay_i,
        input  fab_done_i, fab_result_a_i, fab_result_b_i, fab_result_c_i,
        output req_done_o, req_err_o, result_a_o, result_b_o, result_c_o,
        output fab_en_o, fab_operator_o, fab_operand_a_o, fab_operand_b_o, fab_write_strobe_o,
        output busy_o
    );

    modport master (
        output req_en_i, req_operator_i, req_operand_a_i, req_operand_b_i, req_delay_i,
        output fab_done_i, fab_result_a_i, fab_result_b_i, fab_result_c_i,
        input  req_done_o, req_err_o, result_a_o, result_b_o, result_c_o,
        input  fab_en_o, fab_operator_o, fab_operand_a_o, fab_operand_b_o, fab_write_strobe_o,
        input  busy_o
    );
endinterface

// File: rtl/flexbex_efpga_arbiter.sv
// flexbex_efpga_arbiter: round-robin sharing of one eFPGA fabric between N_REQ
// flexbex cores, one operation in flight. The winner's operator/operands are
// latched, strobed into the fabric, and the op completes after a fixed delay
// (1..15 cycles) or, for delay 0, when the fabric raises done.
// Optional: define EFPGA_ARB_TIMEOUT_EN to add a watchdog on done-driven ops;
// after TIMEOUT_CYCLES WAIT cycles without done, req_err_o pulses instead.
module flexbex_efpga_arbiter #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    flexbex_efpga_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("flexbex_efpga_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("flexbex_efpga_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP,
        COOL
    } state_e;

    state_e state_q, state_d;

    // Arbitration state
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] grant_q;
    logic [PTR_W-1:0] grant_d;
    logic [PTR_W-1:0] scan_idx;
    logic             grant_valid;
    logic             mask_q;        // blocks the last winner for one IDLE cycle
    logic [N_REQ-1:0] req_eligible;

    // Latched operation and completion tracking
    logic [1:0]       operator_q;
    logic [31:0]      operand_a_q;
    logic [31:0]      operand_b_q;
    logic [3:0]       delay_q;
    logic [3:0]       cnt_q;
    logic [31:0]      result_a_q;
    logic [31:0]      result_b_q;
    logic [31:0]      result_c_q;
    logic             wait_exit;     // normal completion this cycle
    logic             timeout_exit;  // watchdog expiry this cycle

    // Decoded outputs
    logic             fab_en;
    logic             write_strobe;
    logic [N_REQ-1:0] done_vec;
    logic [N_REQ-1:0] err_vec;

`ifdef EFPGA_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0]  wd_q;
    logic             timed_out_q;
`endif

    // Per-core request fields as arrays so the winner can be selected by index.
    logic [1:0]  req_op [N_REQ];
    logic [31:0] req_a  [N_REQ];
    logic [31:0] req_b  [N_REQ];
    logic [3:0]  req_d  [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_op[k] = bus.req_operator_i[2*k +: 2];
        assign req_a[k]  = bus.req_operand_a_i[32*k +: 32];
        assign req_b[k]  = bus.req_operand_b_i[32*k +: 32];
        assign req_d[k]  = bus.req_delay_i[4*k +: 4];
    end

    // Round-robin pick: first eligible requester at or after the pointer, wrapping.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path can
        // leave one unassigned and infer a latch.
        req_eligible = bus.req_en_i;
        grant_valid  = 1'b0;
        grant_d      = '0;
        scan_idx     = '0;
        if (mask_q) begin
            req_eligible[grant_q] = 1'b0;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = PTR_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!grant_valid && req_eligible[scan_idx]) begin
                grant_valid = 1'b1;
                grant_d     = scan_idx;
            end
        end
    end

    // State register; reset aborts any operation without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state output decode.
    always_comb begin
        state_d      = state_q;
        wait_exit    = 1'b0;
        timeout_exit = 1'b0;
        fab_en       = 1'b0;
        write_strobe = 1'b0;
        done_vec     = '0;
        err_vec      = '0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                fab_en       = 1'b1;
                write_strobe = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                fab_en = 1'b1;
                if (delay_q != 4'd0) begin
                    // Counter was loaded with d, so reaching 1 marks the d-th cycle.
                    wait_exit = (cnt_q == 4'd1);
                end else begin
                    wait_exit = bus.fab_done_i;
`ifdef EFPGA_ARB_TIMEOUT_EN
                    timeout_exit = !bus.fab_done_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif
                end
                if (wait_exit || timeout_exit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
`ifdef EFPGA_ARB_TIMEOUT_EN
                if (timed_out_q) begin
                    err_vec[grant_q] = 1'b1;
                end else begin
                    done_vec[grant_q] = 1'b1;
                end
`else
                done_vec[grant_q] = 1'b1;
`endif
                state_d = COOL;
            end
            COOL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operation latches, delay counter, result capture and pointer update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            mask_q      <= 1'b0;
            operator_q  <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            delay_q     <= '0;
            cnt_q       <= '0;
            result_a_q  <= '0;
            result_b_q  <= '0;
            result_c_q  <= '0;
`ifdef EFPGA_ARB_TIMEOUT_EN
            wd_q        <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    mask_q <= 1'b0;
                    if (grant_valid) begin
                        grant_q     <= grant_d;
                        operator_q  <= req_op[grant_d];
                        operand_a_q <= req_a[grant_d];
                        operand_b_q <= req_b[grant_d];
                        delay_q     <= req_d[grant_d];
                    end
                end
                STROBE: begin
                    cnt_q <= delay_q;
`ifdef EFPGA_ARB_TIMEOUT_EN
                    wd_q        <= '0;
                    timed_out_q <= 1'b0;
`endif
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                    if (wait_exit) begin
                        result_a_q <= bus.fab_result_a_i;
                        result_b_q <= bus.fab_result_b_i;
                        result_c_q <= bus.fab_result_c_i;
                    end
`ifdef EFPGA_ARB_TIMEOUT_EN
                    if (delay_q == 4'd0 && !bus.fab_done_i) begin
                        wd_q <= wd_q + 1'b1;
                    end
                    timed_out_q <= timeout_exit;
`endif
                end
                RESP: begin
                    rr_ptr_q <= (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
                end
                COOL: begin
                    mask_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_done_o         = done_vec;
    assign bus.req_err_o          = err_vec;
    assign bus.result_a_o         = result_a_q;
    assign bus.result_b_o         = result_b_q;
    assign bus.result_c_o         = result_c_q;
    assign bus.fab_en_o           = fab_en;
    assign bus.fab_operator_o     = operator_q;
    assign bus.fab_operand_a_o    = operand_a_q;
    assign bus.fab_operand_b_o    = operand_b_q;
    assign bus.fab_write_strobe_o = write_strobe;
    assign bus.busy_o             = (state_q != IDLE);

endmodule

// File: doc/flexbex_efpga_arbiter.md
Name: flexbex_efpga_arbiter

Overview:
- Shares one eFPGA fabric between N_REQ flexbex cores. Each core drives its own eFPGA request port.
- Round-robin arbitration, one operation in flight at a time.
- Latches the winner's operands and operator, issues the write strobe, then waits for a fixed delay or for the fabric's done flag.
- Returns registered results with a one-cycle done pulse to the winning core. Sits between the cores' eFPGA ports and the fabric at SoC top.

Parameters:
N_REQ, 2, number of requesting cores (2..8)
TIMEOUT_CYCLES, 255, watchdog limit in cycles for done-driven ops (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_en_i  in  N_REQ  per-core eFPGA enable (request)
req_operator_i  in  2*N_REQ  per-core operator, core k at [2k+1:2k]
req_operand_a_i  in  32*N_REQ  per-core operand A
req_operand_b_i  in  32*N_REQ  per-core operand B
req_delay_i  in  4*N_REQ  per-core delay; 0 means wait for done
req_done_o  out  N_REQ  one-cycle completion pulse per core
req_err_o  out  N_REQ  one-cycle timeout pulse per core (optional feature)
result_a_o  out  32  registered result A (broadcast)
result_b_o  out  32  registered result B
result_c_o  out  32  registered result C
fab_en_o  out  1  fabric enable
fab_operator_o  out  2  latched operator
fab_operand_a_o  out  32  latched operand A
fab_operand_b_o  out  32  latched operand B
fab_write_strobe_o  out  1  one-cycle operand-valid strobe
fab_done_i  in  1  fabric done
fab_result_a_i  in  32  fabric result A
fab_result_b_i  in  32  fabric result B
fab_result_c_i  in  32  fabric result C
busy_o  out  1  state != IDLE

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-low (rst_ni).
- Reset values: all outputs 0, state IDLE, RR pointer 0, latches 0.
- States:
  - IDLE: if any unmasked req_en_i is high, grant the first requester at or after the RR pointer (wrapping). Latch operator, operands and delay. Go to STROBE.
  - STROBE (1 cycle): fab_write_strobe_o=1, fab_en_o=1. Load counter with the latched delay. Go to WAIT.
  - WAIT: fab_en_o=1.
    - Delay d!=0: WAIT lasts exactly d cycles; fab_done_i is ignored.
    - Delay d=0: leave WAIT in the cycle fab_done_i=1 is sampled. fab_done_i is not sampled in STROBE.
    - On exit, register fab_result_*_i into result_*_o. Go to RESP.
  - RESP (1 cycle): req_done_o[grant]=1, fab_en_o=0. RR pointer = grant+1 mod N_REQ. Go to COOL.
  - COOL (1 cycle): no grant. Go to IDLE.
- In IDLE, the previously granted requester is masked for the first IDLE cycle only. The requester must drop req_en_i in the cycle after req_done_o.
- Latency, request sampled in IDLE at cycle t:
  - strobe at t+1
  - done pulse at t+2+d for fixed delay d
  - done pulse at t+3 + (cycles until fab_done_i) for done-driven ops.
- fab_operand/operator outputs hold their latched values from STROBE until the next grant.
- result_*_o hold until the next RESP.
- A requester dropping req_en_i mid-operation does not abort: the operation completes and the done pulse is still issued.
- Simultaneous requests: strict RR order. No requester waits more than N_REQ-1 operations.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- Counter is 4 bits. d=15 gives 15 WAIT cycles. No wrap.

Optional Feature:
- Macro EFPGA_ARB_TIMEOUT_EN.
- Defined:
  - In WAIT with d=0, a watchdog counts cycles. After TIMEOUT_CYCLES cycles without fab_done_i, go to RESP.
  - In that RESP, req_err_o[grant]=1 instead of req_done_o, and result_*_o are not updated.
  - Fixed-delay ops are unaffected.
- Undefined: no watchdog; req_err_o tied to 0; WAIT with d=0 can hang indefinitely.

Test Plan:
- Single op: core0 en, op=2'b01, A=0x12345678, B=0x9, d=3 → one strobe at t+1 with latched A/B, fab_en_o high t+1..t+4, done0 at t+5, result_a_o = fabric value sampled at t+4.
- Done-driven: core1 d=0, fab_done_i raised 5 cycles after strobe → done1 in the cycle after fab_done_i, results captured, fab_en_o low in RESP.
- Contention: cores 0 and 1 hold en continuously with d=1 → grants alternate 0,1,0,1, each done pulse exactly one cycle, never two grants overlapping.
- Abandon: core0 drops en during WAIT (d=4) → op completes, done0 still pulses at t+6.
- Reset mid-WAIT: assert rst_ni low during WAIT → all outputs 0 asynchronously; after release, next request is granted from pointer 0.
- Timeout (EFPGA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10): d=0, fab_done_i never asserted → err pulse 10 cycles into WAIT, no done, results unchanged.
